// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall, redirect flush and memory freeze for a 5-stage pipeline.
// Ports: clk (state on falling edge), Reset (async, active-low),
//   Rs_id/Rt_id/UseRs_id/UseRt_id  - ID instruction sources,
//   Rs_ex/Rt_ex/Rd_ex/RegDst_ex/RegWr_ex/MemtoReg_ex - ID/EX register fields,
//   Redirect_ex (taken branch/jump), MemWait (data memory busy),
//   ForwardA/ForwardB (10 MEM, 01 WB, 00 regfile), StallPC/StallIFID/FlushIFID/BubbleIDEX/FreezeAll,
//   StallCnt/FlushCnt (saturating 16-bit event counters).
module hazard_ctrl (
  input  logic        clk,
  input  logic        Reset,
  input  logic [4:0]  Rs_id,
  input  logic [4:0]  Rt_id,
  input  logic        UseRs_id,
  input  logic        UseRt_id,
  input  logic [4:0]  Rs_ex,
  input  logic [4:0]  Rt_ex,
  input  logic [4:0]  Rd_ex,
  input  logic        RegDst_ex,
  input  logic        RegWr_ex,
  input  logic        MemtoReg_ex,
  input  logic        Redirect_ex,
  input  logic        MemWait,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        StallPC,
  output logic        StallIFID,
  output logic        FlushIFID,
  output logic        BubbleIDEX,
  output logic        FreezeAll,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);
  typedef enum logic [1:0] {RUN, LDSTALL, FREEZE} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_mem_dst, r_wb_dst, w_dst_ex;
  logic        r_mem_wr, r_mem_m2r, r_wb_wr;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_lu, w_run_lu;
  assign w_dst_ex = RegDst_ex ? Rd_ex : Rt_ex;
  // Gated by Reset so stall/bubble stay low while reset is held.
  assign w_lu = Reset & RegWr_ex & MemtoReg_ex & (|w_dst_ex) &
                ((UseRs_id & (w_dst_ex == Rs_id)) | (UseRt_id & (w_dst_ex == Rt_id)));
  // A load in MEM has no data yet, so only its WB copy may be forwarded.
  assign ForwardA = (r_mem_wr & (|r_mem_dst) & ~r_mem_m2r & (r_mem_dst == Rs_ex)) ? 2'b10 :
                    (r_wb_wr & (|r_wb_dst) & (r_wb_dst == Rs_ex)) ? 2'b01 : 2'b00;
  assign ForwardB = (r_mem_wr & (|r_mem_dst) & ~r_mem_m2r & (r_mem_dst == Rt_ex)) ? 2'b10 :
                    (r_wb_wr & (|r_wb_dst) & (r_wb_dst == Rt_ex)) ? 2'b01 : 2'b00;
  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
  always_comb begin
    w_run_lu   = (r_state == RUN) & w_lu;
    w_next     = MemWait ? FREEZE : (w_run_lu & ~Redirect_ex) ? LDSTALL : RUN;
    FreezeAll  = MemWait;
    StallPC    = MemWait | (w_run_lu & ~Redirect_ex);
    StallIFID  = StallPC;
    BubbleIDEX = ~MemWait & (Redirect_ex | w_run_lu);
    FlushIFID  = ~MemWait & Redirect_ex;
  end
  always_ff @(negedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= RUN;
      r_mem_dst   <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_m2r   <= 1'b0;
      r_wb_dst    <= '0;
      r_wb_wr     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (!MemWait) begin
        r_mem_dst <= w_dst_ex;
        r_mem_wr  <= RegWr_ex;
        r_mem_m2r <= MemtoReg_ex;
        r_wb_dst  <= r_mem_dst;
        r_wb_wr   <= r_mem_wr;
      end
      if (StallPC && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (FlushIFID && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
  logic        clk = 1'b1;
  logic        Reset = 1'b1;
  logic [4:0]  Rs_id, Rt_id, Rs_ex, Rt_ex, Rd_ex;
  logic        UseRs_id, UseRt_id, RegDst_ex, RegWr_ex, MemtoReg_ex, Redirect_ex, MemWait;
  logic [1:0]  ForwardA, ForwardB;
  logic        StallPC, StallIFID, FlushIFID, BubbleIDEX, FreezeAll;
  logic [15:0] StallCnt, FlushCnt;
  int          n_chk = 0, n_pass = 0;
  int          m_dst[2];
  bit          m_wr[2], m_ld[2];
  bit          prev_mw, prev_lu;
  int          m_sc, m_fc;
  logic [40:0] m_e;
  hazard_ctrl dut (
    .clk(clk), .Reset(Reset), .Rs_id(Rs_id), .Rt_id(Rt_id), .UseRs_id(UseRs_id), .UseRt_id(UseRt_id),
    .Rs_ex(Rs_ex), .Rt_ex(Rt_ex), .Rd_ex(Rd_ex), .RegDst_ex(RegDst_ex), .RegWr_ex(RegWr_ex),
    .MemtoReg_ex(MemtoReg_ex), .Redirect_ex(Redirect_ex), .MemWait(MemWait),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .StallPC(StallPC), .StallIFID(StallIFID),
    .FlushIFID(FlushIFID), .BubbleIDEX(BubbleIDEX), .FreezeAll(FreezeAll),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [40:0] outs();
    return {ForwardA, ForwardB, StallPC, StallIFID, FlushIFID, BubbleIDEX, FreezeAll, StallCnt, FlushCnt};
  endfunction
  // Youngest writer wins; a load still in MEM cannot supply its data.
  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (!Reset) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (m_wr[k] && m_dst[k] != 0 && !(k == 0 && m_ld[k]) && m_dst[k] == int'(src))
        return k == 0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction
  // State is implied by history: previous edge frozen -> FREEZE, previous edge took a load-use stall -> LDSTALL.
  function automatic logic [40:0] model_out();
    int d;
    bit lu, run, stall;
    d = RegDst_ex ? int'(Rd_ex) : int'(Rt_ex);
    lu = Reset && RegWr_ex && MemtoReg_ex && d != 0 &&
         ((UseRs_id && d == int'(Rs_id)) || (UseRt_id && d == int'(Rt_id)));
    run = Reset && !prev_mw && !prev_lu;
    stall = MemWait || (run && lu && !Redirect_ex);
    return {fwd(Rs_ex), fwd(Rt_ex), stall, stall, !MemWait && Redirect_ex,
            !MemWait && (Redirect_ex || (run && lu)), MemWait,
            Reset ? 16'(m_sc) : 16'd0, Reset ? 16'(m_fc) : 16'd0};
  endfunction
  always @(negedge clk) begin
    if (!Reset) begin
      m_dst = '{0, 0}; m_wr = '{0, 0}; m_ld = '{0, 0};
      prev_mw = 0; prev_lu = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_e = model_out();
      if (m_e[36] && m_sc < 65535) m_sc++;
      if (m_e[34] && m_fc < 65535) m_fc++;
      if (!MemWait) begin
        m_dst[1] = m_dst[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0];
        m_dst[0] = RegDst_ex ? int'(Rd_ex) : int'(Rt_ex);
        m_wr[0] = RegWr_ex; m_ld[0] = MemtoReg_ex;
      end
      prev_lu = m_e[36] && !MemWait;
      prev_mw = MemWait;
    end
  end
  always @(posedge clk) check("cycle_model", outs(), model_out());
  task automatic clr();
    {Rs_id, Rt_id, Rs_ex, Rt_ex, Rd_ex} = '0;
    {UseRs_id, UseRt_id, RegDst_ex, RegWr_ex, MemtoReg_ex, Redirect_ex, MemWait} = '0;
  endtask
  task automatic nxt(); @(negedge clk); #1; endtask
  task automatic mid(); @(posedge clk); #1; endtask
  task automatic rst(); Reset = 0; clr(); nxt(); nxt(); Reset = 1; endtask
  task automatic lw_use();
    RegWr_ex = 1; MemtoReg_ex = 1; RegDst_ex = 0; Rt_ex = 2; Rs_id = 2; UseRs_id = 1;
  endtask
  initial begin
    clr();
    #1 Reset = 0;
    #1 check("reset_outs", outs(), 0);
    nxt();
    Reset = 1;
    rst(); lw_use(); mid();
    check("lu_stall", {StallPC, StallIFID, BubbleIDEX}, 3'b111);
    nxt(); mid();
    check("lu_once", {StallPC, StallIFID, BubbleIDEX}, 3'b000);
    nxt(); clr(); Rs_ex = 2; mid();
    check("lu_fwdA_wb", ForwardA, 2'b01);
    check("lu_stallcnt", StallCnt, 1);
    rst(); RegDst_ex = 1; Rd_ex = 3; RegWr_ex = 1;
    nxt(); clr(); Rs_ex = 3; mid();
    check("alu_fwdA_mem", ForwardA, 2'b10);
    nxt(); clr(); Rt_ex = 3; mid();
    check("alu_fwdB_wb", ForwardB, 2'b01);
    rst(); lw_use(); Redirect_ex = 1; mid();
    check("redir_lu", {FlushIFID, BubbleIDEX, StallPC}, 3'b110);
    nxt(); clr(); mid();
    check("redir_flushcnt", FlushCnt, 1);
    check("redir_stallcnt", StallCnt, 0);
    rst(); RegDst_ex = 1; Rd_ex = 5; RegWr_ex = 1;
    nxt(); clr(); lw_use(); Rs_ex = 5; MemWait = 1;
    repeat (3) begin
      mid();
      check("frz_all", FreezeAll, 1);
      check("frz_sb_held", ForwardA, 2'b10);
      nxt();
    end
    check("frz_stallcnt3", StallCnt, 3);
    MemWait = 0; mid();
    check("frz_exit", {StallPC, ForwardA}, 3'b010);
    nxt(); mid();
    check("post_frz_lu", StallPC, 1);
    nxt();
    check("frz_stallcnt4", StallCnt, 4);
    rst(); MemWait = 1;
    repeat (65534) @(negedge clk);
    #1 check("sat_fffe", StallCnt, 16'hFFFE);
    nxt(); nxt();
    check("sat_ffff", StallCnt, 16'hFFFF);
    nxt();
    check("sat_nowrap", StallCnt, 16'hFFFF);
    mid(); Reset = 0; MemWait = 0;
    #1 check("rst_in_freeze", outs(), 0);
    nxt(); Reset = 1; RegDst_ex = 1; Rd_ex = 0; RegWr_ex = 1; UseRs_id = 1; Rs_id = 0; mid();
    check("r0_no_stall", StallPC, 0);
    nxt(); clr(); mid();
    check("r0_no_fwd_mem", {ForwardA, ForwardB}, 4'b0000);
    nxt(); mid();
    check("r0_no_fwd_wb", {ForwardA, ForwardB}, 4'b0000);
    nxt(); rst();
    repeat (3000) begin
      Rs_id = 5'($urandom_range(0, 3)); Rt_id = 5'($urandom_range(0, 3));
      Rs_ex = 5'($urandom_range(0, 3)); Rt_ex = 5'($urandom_range(0, 3)); Rd_ex = 5'($urandom_range(0, 3));
      {UseRs_id, UseRt_id, RegDst_ex, RegWr_ex, MemtoReg_ex} = 5'($urandom);
      Redirect_ex = $urandom_range(0, 99) < 15;
      MemWait = $urandom_range(0, 99) < 10;
      Reset = $urandom_range(0, 99) != 0;
      nxt();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
